hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding scoreboard for the in-order pipeline.
- Tracks every in-flight register-writing instruction between decode and writeback in a DEPTH-slot shift table.
- For the instruction in decode, produces a load-use/multi-cycle stall, per-operand forwarding selects, and a saturating stall-cycle counter.
- Replaces fixed EX/MEM-only forwarding with configurable depth and per-instruction result latency.

---
 rtl/hazard_scoreboard.sv | 147 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Tracks in-flight register-writing instructions between decode and
//   writeback in a DEPTH-slot shift table (slot 0 = EX, slot DEPTH-1 = WB).
//   For the instruction sitting in decode it produces a hazard stall,
//   per-operand forwarding selects and a saturating stall-cycle counter.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_id_valid            decode holds a real instruction
//   i_id_rs/_rt           source addresses, *_use marks them as read
//   i_id_rd/_regwrite     destination and its write enable
//   i_id_lat              slot index at which the result becomes forwardable
//   i_flush               kill the decode instruction
//   i_hold                global freeze, table and counter keep their value
//   o_stall               decode must repeat next cycle (combinational)
//   o_issue               decode instruction enters slot 0 this edge
//   o_fwd_rs/_rt          0 = register file, k+1 = forward from slot k
//   o_busy                any slot valid (registered)
//   o_stall_count         saturating count of stall cycles (registered)
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = $clog2(NREG),
  parameter int DEPTH = 3,
  parameter int LW    = 2,
  parameter int SW    = $clog2(DEPTH + 1),
  parameter int CW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_id_valid,
  input  logic [AW-1:0] i_id_rs,
  input  logic [AW-1:0] i_id_rt,
  input  logic          i_id_rs_use,
  input  logic          i_id_rt_use,
  input  logic [AW-1:0] i_id_rd,
  input  logic          i_id_regwrite,
  input  logic [LW-1:0] i_id_lat,
  input  logic          i_flush,
  input  logic          i_hold,
  output logic          o_stall,
  output logic          o_issue,
  output logic [SW-1:0] o_fwd_rs,
  output logic [SW-1:0] o_fwd_rt,
  output logic          o_busy,
  output logic [CW-1:0] o_stall_count
);

  localparam int MAX_LAT = DEPTH - 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    rd_q  [DEPTH];
  logic [AW-1:0]    rd_d  [DEPTH];
  logic [LW-1:0]    lat_q [DEPTH];
  logic [LW-1:0]    lat_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;

  logic [DEPTH-1:0] slot_ready;
  logic [SW-1:0]    rs_sel, rt_sel;
  logic             rs_rdy, rt_rdy;
  logic             rs_hit, rt_hit;
  logic             rs_block, rt_block;
  logic             stall, issue;
  logic [LW-1:0]    lat_in;

  // Youngest-match search: scanning from oldest to youngest lets the lowest
  // matching slot overwrite any older one.
  always_comb begin
    rs_sel = '0;
    rt_sel = '0;
    rs_rdy = 1'b0;
    rt_rdy = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      slot_ready[k] = (int'(lat_q[k]) <= k);
      rs_sel = (valid_q[k] && (rd_q[k] == i_id_rs)) ? SW'(k + 1) : rs_sel;
      rs_rdy = (valid_q[k] && (rd_q[k] == i_id_rs)) ? slot_ready[k] : rs_rdy;
      rt_sel = (valid_q[k] && (rd_q[k] == i_id_rt)) ? SW'(k + 1) : rt_sel;
      rt_rdy = (valid_q[k] && (rd_q[k] == i_id_rt)) ? slot_ready[k] : rt_rdy;
    end
    rs_hit   = (rs_sel != '0) && i_id_valid && i_id_rs_use && (i_id_rs != '0);
    rt_hit   = (rt_sel != '0) && i_id_valid && i_id_rt_use && (i_id_rt != '0);
    rs_block = rs_hit && !rs_rdy;
    rt_block = rt_hit && !rt_rdy;
    // A flush kills the decode instruction, so there is nothing to wait for.
    stall    = (rs_block || rt_block) && !i_flush;
    issue    = i_id_valid && !stall && !i_flush && !i_hold;
  end

  // Next table state: shift toward writeback unless frozen; non-issuing
  // cycles and writes to r0 enter slot 0 as a bubble.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    lat_d   = lat_q;
    count_d = count_q;
    lat_in  = (int'(i_id_lat) > MAX_LAT) ? LW'(MAX_LAT) : i_id_lat;
    if (!i_hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k]    = rd_q[k-1];
        lat_d[k]   = lat_q[k-1];
      end
      valid_d[0] = issue && i_id_regwrite && (i_id_rd != '0);
      rd_d[0]    = i_id_rd;
      lat_d[0]   = lat_in;
      if (stall && (count_q != {CW{1'b1}})) begin
        count_d = count_q + CW'(1);
      end else begin
        count_d = count_q;
      end
    end else begin
      valid_d = valid_q;
    end
    busy_d = |valid_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= '0;
        lat_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= rd_d[k];
        lat_q[k] <= lat_d[k];
      end
    end
  end

  assign o_stall       = stall;
  assign o_issue       = issue;
  assign o_fwd_rs      = (rs_hit && rs_rdy) ? rs_sel : '0;
  assign o_fwd_rt      = (rt_hit && rt_rdy) ? rt_sel : '0;
  assign o_busy        = busy_q;
  assign o_stall_count = count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       a_rst, a_valid, a_rsu, a_rtu, a_rw, a_flush, a_hold;
  logic [4:0] a_rs, a_rt, a_rd;
  logic [1:0] a_lat;
  logic       a_stall, a_issue, a_busy;
  logic [1:0] a_frs, a_frt;
  logic [15:0] a_cnt;

  hazard_scoreboard dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_id_valid(a_valid), .i_id_rs(a_rs), .i_id_rt(a_rt),
    .i_id_rs_use(a_rsu), .i_id_rt_use(a_rtu), .i_id_rd(a_rd), .i_id_regwrite(a_rw),
    .i_id_lat(a_lat), .i_flush(a_flush), .i_hold(a_hold), .o_stall(a_stall),
    .o_issue(a_issue), .o_fwd_rs(a_frs), .o_fwd_rt(a_frt), .o_busy(a_busy),
    .o_stall_count(a_cnt));

  // Instance B: deep table, long latency, 2-bit counter
  logic       b_rst, b_valid, b_rsu, b_rtu, b_rw, b_flush, b_hold;
  logic [4:0] b_rs, b_rt, b_rd;
  logic [2:0] b_lat;
  logic       b_stall, b_issue, b_busy;
  logic [3:0] b_frs, b_frt;
  logic [1:0] b_cnt;

  hazard_scoreboard #(.DEPTH(8), .LW(3), .CW(2)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_id_valid(b_valid), .i_id_rs(b_rs), .i_id_rt(b_rt),
    .i_id_rs_use(b_rsu), .i_id_rt_use(b_rtu), .i_id_rd(b_rd), .i_id_regwrite(b_rw),
    .i_id_lat(b_lat), .i_flush(b_flush), .i_hold(b_hold), .o_stall(b_stall),
    .o_issue(b_issue), .o_fwd_rs(b_frs), .o_fwd_rt(b_frt), .o_busy(b_busy),
    .o_stall_count(b_cnt));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int rst, valid, rs, rsu, rt, rtu, rd, rw, lat, flush, hold;
    int e_stall, e_issue, e_frs, e_frt, e_busy, e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rst, int valid, int rs, int rsu, int rt, int rtu,
                              int rd, int rw, int lat, int flush, int hold,
                              int es, int ei, int efs, int eft, int eb, int ec);
    vec_t v;
    v.rst = rst; v.valid = valid; v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu;
    v.rd = rd; v.rw = rw; v.lat = lat; v.flush = flush; v.hold = hold;
    v.e_stall = es; v.e_issue = ei; v.e_frs = efs; v.e_frt = eft; v.e_busy = eb; v.e_cnt = ec;
    return v;
  endfunction

  task automatic drive_a(input int rst, input int valid, input int rs, input int rsu,
                         input int rt, input int rtu, input int rd, input int rw,
                         input int lat, input int flush, input int hold);
    a_rst = 1'(rst); a_valid = 1'(valid); a_rs = 5'(rs); a_rsu = 1'(rsu);
    a_rt = 5'(rt); a_rtu = 1'(rtu); a_rd = 5'(rd); a_rw = 1'(rw);
    a_lat = 2'(lat); a_flush = 1'(flush); a_hold = 1'(hold);
  endtask

  // Reference model: list of in-flight writers with their age in cycles
  typedef struct { int rd; int lat; int age; } ent_t;
  ent_t m_q[$];
  int   m_cnt;

  function automatic void src_eval(input int s, input int use_, input int valid,
                                   output int fwd, output int blk);
    int best;
    int eff;
    best = -1;
    fwd = 0;
    blk = 0;
    if (valid == 0 || use_ == 0 || s == 0) return;
    foreach (m_q[i])
      if (m_q[i].rd == s && (best < 0 || m_q[i].age < m_q[best].age)) best = i;
    if (best < 0) return;
    eff = (m_q[best].lat > DEPTH - 1) ? DEPTH - 1 : m_q[best].lat;
    if (m_q[best].age >= eff) fwd = m_q[best].age + 1;
    else blk = 1;
  endfunction

  initial begin
    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    b_rst = 1'b1; b_valid = 1'b0; b_rs = 5'd0; b_rt = 5'd0; b_rsu = 1'b0; b_rtu = 1'b0;
    b_rd = 5'd0; b_rw = 1'b0; b_lat = 3'd0; b_flush = 1'b0; b_hold = 1'b0;

    //           rst v  rs su rt tu rd rw lt fl ho | st is frs frt busy cnt
    vecs.push_back(mk(0,1, 1,1, 2,1, 3,1,0,0,0,  0,1,0,0,0,0));  // ALU r3
    vecs.push_back(mk(0,1, 3,1, 4,1, 6,1,0,0,0,  0,1,1,0,1,0));  // r3 from slot0
    vecs.push_back(mk(0,1, 3,1, 0,0, 0,1,0,0,0,  0,1,2,0,1,0));  // r3 from slot1, rd=r0
    vecs.push_back(mk(0,1, 1,0, 2,0, 5,1,1,0,0,  0,1,0,0,1,0));  // load r5
    vecs.push_back(mk(0,1, 8,1, 5,1, 9,1,0,0,0,  1,0,0,0,1,0));  // load-use stall
    vecs.push_back(mk(0,1, 8,1, 5,1, 9,1,0,0,0,  0,1,0,2,1,1));  // resolved
    vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,0,0,0,  0,1,0,0,1,1));  // r7
    vecs.push_back(mk(0,1, 0,0, 0,0,11,1,0,0,0,  0,1,0,0,1,1));  // r11
    vecs.push_back(mk(0,1,11,1, 0,0, 7,1,0,0,0,  0,1,1,0,1,1));  // r7 again
    vecs.push_back(mk(0,1, 7,1, 0,1,12,1,0,0,0,  0,1,1,0,1,1));  // youngest r7, r0 src
    vecs.push_back(mk(0,1, 0,0, 0,0,13,1,1,0,0,  0,1,0,0,1,1));  // load r13
    vecs.push_back(mk(0,1,13,1, 0,0,14,1,0,1,0,  0,0,0,0,1,1));  // flush over hazard
    vecs.push_back(mk(0,1,13,1, 0,0,14,1,0,0,0,  0,1,2,0,1,1));  // load kept shifting
    vecs.push_back(mk(0,1, 0,0, 0,0,15,1,1,0,0,  0,1,0,0,1,1));  // load r15
    vecs.push_back(mk(0,1, 0,0,15,1,16,1,0,0,1,  1,0,0,0,1,1));  // hold 1
    vecs.push_back(mk(0,1, 0,0,15,1,16,1,0,0,1,  1,0,0,0,1,1));  // hold 2
    vecs.push_back(mk(0,1, 0,0,15,1,16,1,0,0,1,  1,0,0,0,1,1));  // hold 3
    vecs.push_back(mk(0,1, 0,0,15,1,16,1,0,0,0,  1,0,0,0,1,1));  // released
    vecs.push_back(mk(0,1, 0,0,15,1,16,1,0,0,0,  0,1,0,2,1,2));  // resolved
    vecs.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0,0,  0,0,0,0,1,2));  // reset mid-stream
    vecs.push_back(mk(0,1,16,1,15,1,17,1,0,0,0,  0,1,0,0,0,0));  // only regfile
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,0,0,1,0));  // drain
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,0,0,0,0));  // empty again
    vecs.push_back(mk(0,1, 0,0, 0,0,20,1,3,0,0,  0,1,0,0,0,0));  // lat 3 clamps to 2
    vecs.push_back(mk(0,1,20,1, 0,0,21,1,0,0,0,  1,0,0,0,1,0));
    vecs.push_back(mk(0,1,20,1, 0,0,21,1,0,0,0,  1,0,0,0,1,1));
    vecs.push_back(mk(0,1,20,1, 0,0,21,1,0,0,0,  0,1,3,0,1,2));  // from WB slot

    @(posedge clk);
    @(posedge clk);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      drive_a(v.rst, v.valid, v.rs, v.rsu, v.rt, v.rtu, v.rd, v.rw, v.lat, v.flush, v.hold);
      #1;
      chk($sformatf("vec%0d stall", i), int'(a_stall), v.e_stall);
      chk($sformatf("vec%0d issue", i), int'(a_issue), v.e_issue);
      chk($sformatf("vec%0d fwd_rs", i), int'(a_frs), v.e_frs);
      chk($sformatf("vec%0d fwd_rt", i), int'(a_frt), v.e_frt);
      chk($sformatf("vec%0d busy", i), int'(a_busy), v.e_busy);
      chk($sformatf("vec%0d count", i), int'(a_cnt), v.e_cnt);
    end

    // Randomized run against the reference model
    @(negedge clk);
    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    m_q.delete();
    m_cnt = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int rst, valid, rs, rsu, rt, rtu, rd, rw, lat, flush, hold;
      int fa, ba, fb, bb, e_stall, e_issue;
      if (cyc != 0) @(negedge clk);
      rst = ($urandom_range(99) == 0) ? 1 : 0;
      valid = ($urandom_range(4) != 0) ? 1 : 0;
      rs = $urandom_range(7); rt = $urandom_range(7); rd = $urandom_range(7);
      rsu = $urandom_range(1); rtu = $urandom_range(1); rw = ($urandom_range(4) != 0) ? 1 : 0;
      lat = $urandom_range(3);
      flush = ($urandom_range(9) == 0) ? 1 : 0;
      hold = ($urandom_range(6) == 0) ? 1 : 0;
      drive_a(rst, valid, rs, rsu, rt, rtu, rd, rw, lat, flush, hold);
      #1;
      src_eval(rs, rsu, valid, fa, ba);
      src_eval(rt, rtu, valid, fb, bb);
      e_stall = ((ba | bb) != 0 && flush == 0) ? 1 : 0;
      e_issue = (valid == 1 && e_stall == 0 && flush == 0 && hold == 0) ? 1 : 0;
      chk("rnd stall", int'(a_stall), e_stall);
      chk("rnd issue", int'(a_issue), e_issue);
      chk("rnd fwd_rs", int'(a_frs), fa);
      chk("rnd fwd_rt", int'(a_frt), fb);
      chk("rnd busy", int'(a_busy), (m_q.size() != 0) ? 1 : 0);
      chk("rnd count", int'(a_cnt), m_cnt);
      // model the coming clock edge
      if (rst == 1) begin
        m_q.delete();
        m_cnt = 0;
      end else if (hold == 0) begin
        foreach (m_q[i]) m_q[i].age++;
        for (int i = m_q.size() - 1; i >= 0; i--)
          if (m_q[i].age >= DEPTH) m_q.delete(i);
        if (e_issue == 1 && rw == 1 && rd != 0) m_q.push_back('{rd, lat, 0});
        if (e_stall == 1 && m_cnt < 65535) m_cnt++;
      end
    end

    // Instance B: long stall saturates the 2-bit counter, then mid-stream reset
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    b_rst = 1'b0;
    b_valid = 1'b1; b_rd = 5'd1; b_rw = 1'b1; b_lat = 3'd7;
    #1;
    chk("B producer issue", int'(b_issue), 1);
    @(negedge clk);
    b_rs = 5'd1; b_rsu = 1'b1; b_rd = 5'd2; b_lat = 3'd0;
    #1;
    chk("B stall start", int'(b_stall), 1);
    chk("B count start", int'(b_cnt), 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("B stall %0d", i), int'(b_stall), 1);
      chk($sformatf("B count %0d", i), int'(b_cnt), (i > 3) ? 3 : i);
    end
    chk("B busy before reset", int'(b_busy), 1);
    @(negedge clk);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0; b_valid = 1'b0;
    #1;
    chk("B busy after reset", int'(b_busy), 0);
    chk("B count after reset", int'(b_cnt), 0);
    chk("B stall after reset", int'(b_stall), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
